vram_write_arbiter: RTL and testbench

//  Shares the single write port of the video RAM between two requesters
//  (port 0: CPU/instruction path; port 1: text/sprite writer).

---
 rtl/vram_arb_pkg.sv | 22 ++
 rtl/rr_arbiter2.sv | 38 +++
 rtl/vram_write_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_vram_write_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// Shared encodings for the VRAM write arbiter: FSM states, grant sources and
// the round-robin pointer values.
package vram_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_P0   = 2'd1,
    GNT_P1   = 2'd2,
    GNT_CLR  = 2'd3
  } gnt_e;

  // The pointer holds the port that was granted last.
  localparam logic PTR_P0     = 1'b0;
  localparam logic PTR_P1     = 1'b1;
  localparam logic RR_PTR_RST = PTR_P1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic. Purely combinational; the caller keeps the
// pointer register and loads ptr_o every cycle.
module rr_arbiter2
  import vram_arb_pkg::*;
(
  input  logic       ptr_i,
  input  logic [1:0] elig_i,
  output logic [1:0] gnt_o,
  output logic       ptr_o
);

  always_comb begin
    gnt_o = 2'b00;
    ptr_o = ptr_i;
    case (elig_i)
      2'b01: begin
        gnt_o = 2'b01;
        ptr_o = PTR_P0;
      end
      2'b10: begin
        gnt_o = 2'b10;
        ptr_o = PTR_P1;
      end
      2'b11: begin
        // Tie: the port that was not served last goes first.
        if (ptr_i == PTR_P1) begin
          gnt_o = 2'b01;
          ptr_o = PTR_P0;
        end else begin
          gnt_o = 2'b10;
          ptr_o = PTR_P1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vram_write_arbiter.sv
// Shares the VRAM write port between two req/ack requesters with round-robin
// fairness; the screen-clear engine is built only when VRAM_ARB_CLEAR_EN is defined.
module vram_write_arbiter
  import vram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_SIZE   = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iReq0,
  input  logic [ADDR_WIDTH-1:0] iAddr0,
  input  logic [DATA_WIDTH-1:0] iData0,
  output logic                  oAck0,
  input  logic                  iReq1,
  input  logic [ADDR_WIDTH-1:0] iAddr1,
  input  logic [DATA_WIDTH-1:0] iData1,
  output logic                  oAck1,
  input  logic                  iClearReq,
  input  logic [DATA_WIDTH-1:0] iClearValue,
  output logic                  oClearBusy,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [DATA_WIDTH-1:0] oWriteData
);

  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic                  busy_q, busy_d;
  logic                  ptr_q, ptr_d;

  logic [1:0]            elig;
  logic [1:0]            elig_arb;
  logic [1:0]            rr_gnt;
  logic                  rr_ptr_nxt;
  gnt_e                  gnt;

  logic                  clr_start;
  logic                  clr_write;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [DATA_WIDTH-1:0] clr_data;

`ifdef VRAM_ARB_CLEAR_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    clr_start = 1'b0;
    clr_write = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iClearReq) begin
          state_d   = ST_CLEAR;
          cnt_d     = '0;
          fill_d    = iClearValue;
          clr_start = 1'b1;
        end
      end
      ST_CLEAR: begin
        // Further clear requests are ignored until the last word is written.
        clr_write = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign clr_addr = cnt_q;
  assign clr_data = fill_q;
  assign busy_d   = (state_d == ST_CLEAR);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
    end
  end
`else
  logic unused_clear_in;

  assign clr_start       = 1'b0;
  assign clr_write       = 1'b0;
  assign clr_addr        = '0;
  assign clr_data        = '0;
  assign busy_d          = 1'b0;
  assign unused_clear_in = ^{iClearReq, iClearValue, ADDR_WIDTH'(MEM_SIZE)};
`endif

  // A request whose ack is currently high has already been served.
  always_comb begin
    elig     = {iReq1 & ~ack1_q, iReq0 & ~ack0_q};
    elig_arb = (clr_start | clr_write) ? 2'b00 : elig;
  end

  rr_arbiter2 u_rr (
    .ptr_i  (ptr_q),
    .elig_i (elig_arb),
    .gnt_o  (rr_gnt),
    .ptr_o  (rr_ptr_nxt)
  );

  always_comb begin
    gnt = GNT_NONE;
    if (clr_write) begin
      gnt = GNT_CLR;
    end else if (rr_gnt[0]) begin
      gnt = GNT_P0;
    end else if (rr_gnt[1]) begin
      gnt = GNT_P1;
    end
  end

  always_comb begin
    we_d   = 1'b0;
    ack0_d = 1'b0;
    ack1_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    ptr_d  = rr_ptr_nxt;
    case (gnt)
      GNT_P0: begin
        we_d   = 1'b1;
        ack0_d = 1'b1;
        addr_d = iAddr0;
        data_d = iData0;
      end
      GNT_P1: begin
        we_d   = 1'b1;
        ack1_d = 1'b1;
        addr_d = iAddr1;
        data_d = iData1;
      end
      GNT_CLR: begin
        we_d   = 1'b1;
        addr_d = clr_addr;
        data_d = clr_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      busy_q <= 1'b0;
      ptr_q  <= RR_PTR_RST;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      ack0_q <= ack0_d;
      ack1_q <= ack1_d;
      busy_q <= busy_d;
      ptr_q  <= ptr_d;
    end
  end

  assign oWriteEnable  = we_q;
  assign oWriteAddress = addr_q;
  assign oWriteData    = data_q;
  assign oAck0         = ack0_q;
  assign oAck1         = ack1_q;
  assign oClearBusy    = busy_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Bench for vram_write_arbiter: vector table, clear/reset sequences and random
// traffic against a cycle-level reference model; adapts to VRAM_ARB_CLEAR_EN.
module tb_vram_write_arbiter;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int MS = 8;
`ifdef VRAM_ARB_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          Reset;
  logic          iReq0, iReq1, iClearReq;
  logic [AW-1:0] iAddr0, iAddr1;
  logic [DW-1:0] iData0, iData1, iClearValue;
  logic          oAck0, oAck1, oClearBusy, oWriteEnable;
  logic [AW-1:0] oWriteAddress;
  logic [DW-1:0] oWriteData;

  vram_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS)) dut (
    .Clock(Clock), .Reset(Reset),
    .iReq0(iReq0), .iAddr0(iAddr0), .iData0(iData0), .oAck0(oAck0),
    .iReq1(iReq1), .iAddr1(iAddr1), .iData1(iData1), .oAck1(oAck1),
    .iClearReq(iClearReq), .iClearValue(iClearValue), .oClearBusy(oClearBusy),
    .oWriteEnable(oWriteEnable), .oWriteAddress(oWriteAddress), .oWriteData(oWriteData)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] ram [256];

  // Reference model state: outputs expected after the most recent edge.
  logic          m_we, m_ack0, m_ack1, m_busy;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_fill;
  int            m_last;
  bit            m_clearing;
  int            m_clr_addr;

  typedef struct packed {
    logic r0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic r1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic ewe; logic [AW-1:0] eaddr; logic [DW-1:0] edata; logic eack0; logic eack1;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input logic r0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic r1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic ewe, input logic [AW-1:0] eaddr, input logic [DW-1:0] edata,
                              input logic eack0, input logic eack1);
    vec_t v;
    v = '{r0, a0, d0, r1, a1, d1, ewe, eaddr, edata, eack0, eack1};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_we = 0; m_ack0 = 0; m_ack1 = 0; m_busy = 0;
    m_addr = '0; m_data = '0; m_fill = '0;
    m_last = 1; m_clearing = 0; m_clr_addr = 0;
  endtask

  // One rising edge of the specified behaviour, using the inputs seen at that edge.
  task automatic m_step();
    bit e0, e1;
    int win;
    if (m_clearing) begin
      m_we = 1; m_addr = AW'(m_clr_addr); m_data = m_fill; m_ack0 = 0; m_ack1 = 0;
      if (m_clr_addr == MS) begin
        m_clearing = 0; m_busy = 0;
      end else begin
        m_clr_addr++;
      end
    end else if (CLR_EN && iClearReq) begin
      m_clearing = 1; m_clr_addr = 0; m_fill = iClearValue; m_busy = 1;
      m_we = 0; m_ack0 = 0; m_ack1 = 0;
    end else begin
      e0 = iReq0 && !m_ack0;
      e1 = iReq1 && !m_ack1;
      win = -1;
      if (e0 && e1) win = (m_last == 0) ? 1 : 0;
      else if (e0) win = 0;
      else if (e1) win = 1;
      m_we = (win >= 0); m_ack0 = (win == 0); m_ack1 = (win == 1);
      if (win == 0) begin m_addr = iAddr0; m_data = iData0; m_last = 0; end
      if (win == 1) begin m_addr = iAddr1; m_data = iData1; m_last = 1; end
    end
  endtask

  task automatic compare_model();
    check("model", {oClearBusy, oAck1, oAck0, oWriteEnable, oWriteAddress, oWriteData},
                   {m_busy, m_ack1, m_ack0, m_we, m_addr, m_data});
  endtask

  task automatic tick(input bit cmp);
    @(posedge Clock);
    if (Reset) m_reset(); else m_step();
    @(negedge Clock);
    if (!Reset && cmp) compare_model();
    if (oWriteEnable) ram[oWriteAddress] = oWriteData;
  endtask

  task automatic async_reset(input string name);
    #2 Reset = 1'b1;
    m_reset();
    #1 check(name, {oClearBusy, oAck1, oAck0, oWriteEnable, oWriteAddress, oWriteData}, 32'h0);
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic drive_random();
    if (iReq0) begin
      if (oAck0) begin
        if ($urandom_range(1, 0) != 0) begin iAddr0 = AW'($urandom); iData0 = DW'($urandom); end
        else iReq0 = 1'b0;
      end
    end else if ($urandom_range(9, 0) < 4) begin
      iReq0 = 1'b1; iAddr0 = AW'($urandom); iData0 = DW'($urandom);
    end
    if (iReq1) begin
      if (oAck1) begin
        if ($urandom_range(1, 0) != 0) begin iAddr1 = AW'($urandom); iData1 = DW'($urandom); end
        else iReq1 = 1'b0;
      end
    end else if ($urandom_range(9, 0) < 4) begin
      iReq1 = 1'b1; iAddr1 = AW'($urandom); iData1 = DW'($urandom);
    end
    iClearReq = ($urandom_range(99, 0) < 3);
    iClearValue = DW'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, wr_cnt, exp_a, fall, ackc;
    bit seen_busy;

    tbl[0]  = mk(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 0, 0);
    tbl[1]  = mk(1, 8'h03, 16'hBEEF, 0, 8'h00, 16'h0000, 1, 8'h03, 16'hBEEF, 1, 0);
    tbl[2]  = mk(1, 8'h03, 16'hBEEF, 0, 8'h00, 16'h0000, 0, 8'h03, 16'hBEEF, 0, 0);
    tbl[3]  = mk(1, 8'h03, 16'hBEEF, 0, 8'h00, 16'h0000, 1, 8'h03, 16'hBEEF, 1, 0);
    tbl[4]  = mk(0, 8'h00, 16'h0000, 1, 8'h05, 16'h1234, 1, 8'h05, 16'h1234, 0, 1);
    tbl[5]  = mk(1, 8'h07, 16'h1111, 1, 8'h09, 16'h2222, 1, 8'h07, 16'h1111, 1, 0);
    tbl[6]  = mk(1, 8'h08, 16'h3333, 1, 8'h09, 16'h2222, 1, 8'h09, 16'h2222, 0, 1);
    tbl[7]  = mk(1, 8'h08, 16'h3333, 1, 8'h0A, 16'h4444, 1, 8'h08, 16'h3333, 1, 0);
    tbl[8]  = mk(0, 8'h00, 16'h0000, 1, 8'h0A, 16'h4444, 1, 8'h0A, 16'h4444, 0, 1);
    tbl[9]  = mk(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 0, 8'h0A, 16'h4444, 0, 0);
    tbl[10] = mk(1, 8'h01, 16'hAAAA, 1, 8'h02, 16'hBBBB, 1, 8'h01, 16'hAAAA, 1, 0);
    tbl[11] = mk(0, 8'h00, 16'h0000, 1, 8'h02, 16'hBBBB, 1, 8'h02, 16'hBBBB, 0, 1);
    tbl[12] = mk(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 0, 8'h02, 16'hBBBB, 0, 0);
    tbl[13] = mk(1, 8'h04, 16'hC0C0, 0, 8'h00, 16'h0000, 1, 8'h04, 16'hC0C0, 1, 0);
    tbl[14] = mk(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 0, 8'h04, 16'hC0C0, 0, 0);
    tbl[15] = mk(1, 8'h06, 16'h0101, 1, 8'h07, 16'h0202, 1, 8'h07, 16'h0202, 0, 1);
    tbl[16] = mk(1, 8'h06, 16'h0101, 0, 8'h00, 16'h0000, 1, 8'h06, 16'h0101, 1, 0);
    tbl[17] = mk(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 0, 8'h06, 16'h0101, 0, 0);
    tbl[18] = mk(1, 8'h08, 16'h5A5A, 1, 8'h08, 16'hA5A5, 1, 8'h08, 16'hA5A5, 0, 1);
    tbl[19] = mk(1, 8'h08, 16'h5A5A, 0, 8'h00, 16'h0000, 1, 8'h08, 16'h5A5A, 1, 0);
    tbl[20] = mk(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 0, 8'h08, 16'h5A5A, 0, 0);

    for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    Reset = 1'b1;
    iReq0 = 0; iReq1 = 0; iClearReq = 0;
    iAddr0 = '0; iAddr1 = '0; iData0 = '0; iData1 = '0; iClearValue = '0;
    m_reset();
    @(negedge Clock);
    @(negedge Clock);
    check("reset_init", {oClearBusy, oAck1, oAck0, oWriteEnable, oWriteAddress, oWriteData}, 32'h0);
    Reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      iReq0 = tbl[i].r0; iAddr0 = tbl[i].a0; iData0 = tbl[i].d0;
      iReq1 = tbl[i].r1; iAddr1 = tbl[i].a1; iData1 = tbl[i].d1;
      tick(1'b0);
      check($sformatf("vec%0d", i),
            {oClearBusy, oAck1, oAck0, oWriteEnable, oWriteAddress, oWriteData},
            {1'b0, tbl[i].eack1, tbl[i].eack0, tbl[i].ewe, tbl[i].eaddr, tbl[i].edata});
    end
    check("ram_word3", ram[3], 16'hBEEF);

    // Asynchronous reset right after a grant, then a tie on release.
    iReq0 = 1; iAddr0 = 8'h33; iData0 = 16'h7777;
    tick(1'b1);
    iReq0 = 1; iAddr0 = 8'h11; iData0 = 16'h1010;
    iReq1 = 1; iAddr1 = 8'h22; iData1 = 16'h2020;
    async_reset("reset_async");
    tick(1'b1);
    check("reset_first_grant", {oAck1, oAck0}, 2'b01);
    iReq0 = 0;
    tick(1'b1);
    iReq1 = 0;
    tick(1'b1);
    tick(1'b1);

`ifdef VRAM_ARB_CLEAR_EN
    // Clear with port 1 pending and a repeated clear request mid-way.
    iClearReq = 1; iClearValue = 16'h0020;
    iReq1 = 1; iAddr1 = 8'h44; iData1 = 16'h9999;
    busy_cnt = 0; wr_cnt = 0; exp_a = 0; fall = -1; ackc = -1; seen_busy = 0;
    for (int c = 0; c < 30 && ackc < 0; c++) begin
      tick(1'b1);
      iClearReq = (c == 3);
      if (c == 3) iClearValue = 16'hFFFF;
      if (oClearBusy) begin
        busy_cnt++; seen_busy = 1;
      end else if (seen_busy && fall < 0) begin
        fall = c;
      end
      if (oAck1) begin
        ackc = c;
        iReq1 = 0;
      end else if (oWriteEnable) begin
        check("clear_addr", 32'(oWriteAddress), exp_a);
        check("clear_data", oWriteData, 16'h0020);
        exp_a++; wr_cnt++;
      end
    end
    iClearReq = 0;
    check("clear_busy_cycles", busy_cnt, MS + 1);
    check("clear_write_count", wr_cnt, MS + 1);
    check("ack1_after_clear", ackc, fall + 1);
    for (int i = 0; i <= MS; i++) check($sformatf("ram_clear%0d", i), ram[i], 16'h0020);
    tick(1'b1);

    // Reset in the middle of a clear leaves the remaining words alone.
    iClearReq = 1; iClearValue = 16'h5555;
    tick(1'b1);
    iClearReq = 0;
    for (int c = 0; c < 3; c++) tick(1'b1);
    async_reset("reset_mid_clear");
    for (int c = 0; c < 4; c++) tick(1'b1);
    check("clear_abort_untouched", ram[MS], 16'h0020);
    check("clear_abort_written", ram[1], 16'h5555);
`else
    // Clear pulse must have no visible effect in this build.
    iClearReq = 1; iClearValue = 16'h0020;
    busy_cnt = 0; wr_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick(1'b1);
      iClearReq = 0;
      if (oClearBusy) busy_cnt++;
      if (oWriteEnable) wr_cnt++;
    end
    check("noclr_busy", busy_cnt, 0);
    check("noclr_writes", wr_cnt, 0);
    iClearReq = 1; iReq1 = 1; iAddr1 = 8'h44; iData1 = 16'h9999;
    tick(1'b1);
    iClearReq = 0; iReq1 = 0;
    check("noclr_req_immediate", {oAck1, oWriteAddress, oWriteData}, {1'b1, 8'h44, 16'h9999});
    tick(1'b1);
`endif

    for (int c = 0; c < 2000; c++) begin
      tick(1'b1);
      if (c == 700 || c == 1400) begin
        iClearReq = 0;
        async_reset("reset_random");
      end else begin
        drive_random();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
